rapids_cpu: RTL and testbench
=============================

Name: rapids_cpu

Overview:
- Small multi-cycle 32-bit processor core.
- Contains a unified word-addressed instruction/data memory and a 16-entry register file.
- A one-cycle `go` pulse starts execution at address 0. The `halt` input stops it.
- Memory and registers must be reachable by hierarchical name so benches can preload programs and check results: memory instance `mmu` with array `memory`; register-file instance `D` with array `registers`.

Parameters:
- MEM_WORDS, 256, number of 32-bit memory words; index = address[7:0], upper address bits ignored.
- NUM_REGS, 16, register-file entries, each 32 bits.

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- reset_n, input, 1, synchronous active-high reset. The name is historical; the port is asserted when 1.
- go, input, 1, start pulse; sampled only in IDLE.
- halt, input, 1, stop request; sampled in every state.

Behaviour:
- Reset (reset_n=1 at a clk edge):
  - state=IDLE, PC=0, IR=0, all registers=0.
  - Memory contents are NOT reset, so preloaded programs survive.
- States: IDLE, FETCH, EXEC, MEM.
- IDLE:
  - If go=1 and halt=0, set PC=0 and go to FETCH. Otherwise stay.
  - Memory may be written externally while in IDLE.
- FETCH: IR<=memory[PC]; PC<=PC+1 (wraps modulo MEM_WORDS); go to EXEC.
- EXEC decodes IR[31:28]:
  - 0x9, immediate move: if IR[27:20]==8'hEF, then registers[IR[19:16]] <= zero-extended IR[15:0]; otherwise NOP. Next state FETCH.
  - 0x8, ALU reg-reg: rd=IR[15:12], rs=IR[7:4]; rd <= rd OP rs. Next state FETCH.
    - IR[27:24] selects OP: 0 add, 1 sub, 2 and, 3 or, 4 xor; other codes are NOP.
    - Arithmetic is 32-bit with wrap-around; no flags.
    - IR[23:16] and IR[11:8], IR[3:0] are ignored.
  - 0x2, store: src=IR[27:24], addr reg=IR[23:20], byte mask=IR[19:16].
    - For each mask bit i set, memory[reg[addr]] byte i <= reg[src] byte i.
    - Mask 0xF writes the full word. Next state FETCH.
  - 0x1, load: dest=IR[27:24], addr reg=IR[23:20], mask=IR[19:16]. Go to MEM.
  - 0xF: halt instruction; go to IDLE.
  - Any other opcode, including 0x0: NOP; go to FETCH.
- MEM: registers[dest] <= memory[reg[addr]] with unselected bytes forced to 0; go to FETCH.
- Timing:
  - Immediate, ALU, store and NOP take 2 cycles.
  - Load takes 3 cycles.
  - The first FETCH occurs on the edge after go is sampled.
- Register 0 is an ordinary writable register.
- Same-instruction read/write, e.g. rd==rs, uses the old values.
- halt=1 in any non-IDLE state forces IDLE on the next edge. An in-flight EXEC/MEM write still completes on that edge. PC is retained.
- go while running is ignored.
- reset_n mid-execution has priority over everything and returns the core to IDLE with registers cleared.
- Store to the currently fetched word's address takes effect for later fetches only.

Test Plan:
- Arithmetic:
  - Program: mem[0]=9EF10004, mem[1]=9EF20006, mem[2]=80801020; pulse go; wait 20 cycles.
  - Expect registers[1]=10, registers[2]=6.
- Store/load:
  - Continue the program with mem[3]=9EF30040, mem[4]=213F0000, mem[5]=143F0000.
  - Expect memory[64]=10, registers[4]=10, registers[3]=64, all within 20 cycles of go.
- Byte mask:
  - Setup: r1=0xAABBCCDD (via stores/loads or preload), mem[64]=0.
  - Store with mask 0x3 (instruction 0x21330000) -> memory[64]=0x0000CCDD.
  - Load with mask 0x4 -> dest=0x00BB0000.
- ALU ops and wrap:
  - Set r1=0, r2=1.
  - Sub (0x81001020) -> r1=0xFFFFFFFF.
  - Then add r1+=r2 -> r1=0.
- Halt:
  - Assert halt one cycle after go -> core returns to IDLE; later instructions do not execute; registers unchanged afterwards.
  - Program with 0xF0000000 at mem[1] -> core idles after instruction 0.
- Reset:
  - Assert reset_n=1 mid-program -> next cycle all registers=0, state IDLE, memory contents preserved.
  - A new go pulse re-runs the program from PC 0.

Source files
------------

// File: rtl/rapids_cpu_if.sv
// Control handshake for rapids_cpu: a one-cycle go pulse starts a run; halt parks the core in IDLE.
interface rapids_cpu_if;
  logic go;
  logic halt;

  modport master (output go, output halt);
  modport slave  (input go, input halt);
endinterface

// File: rtl/rapids_cpu.sv
// rapids_cpu: multi-cycle 32-bit core with unified word memory and a 16-entry register file.
// Two clocks per instruction (three for loads); go starts at address 0, halt parks the core in IDLE.

module rapids_mem #(
  parameter int MEM_WORDS = 256,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] fetch_addr,
  output logic [31:0]   fetch_dat,
  input  logic [AW-1:0] data_addr,
  output logic [31:0]   data_dat,
  input  logic          wr_en,
  input  logic [3:0]    wr_mask,
  input  logic [31:0]   wr_dat
);
  // Contents are deliberately never reset so preloaded programs survive a reset.
  logic [31:0] memory [MEM_WORDS];

  assign fetch_dat = memory[fetch_addr];
  assign data_dat  = memory[data_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) memory[data_addr][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
  end
endmodule

module rapids_regfile #(
  parameter int NUM_REGS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rd_addr_a,
  output logic [31:0] rd_dat_a,
  input  logic [3:0]  rd_addr_b,
  output logic [31:0] rd_dat_b,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_dat
);
  logic [31:0] registers [NUM_REGS];

  assign rd_dat_a = registers[rd_addr_a];
  assign rd_dat_b = registers[rd_addr_b];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) registers[i] <= '0;
    end else if (wr_en) begin
      registers[wr_addr] <= wr_dat;
    end
  end
endmodule

module rapids_cpu #(
  parameter int MEM_WORDS = 256,
  parameter int NUM_REGS  = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  rapids_cpu_if.slave   ctl
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    MEM   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic [31:0]   ir, ir_nxt;

  logic [3:0]    opcode;
  logic [3:0]    rf_ra_a, rf_ra_b, rf_wa;
  logic [31:0]   rf_rd_a, rf_rd_b, rf_wd;
  logic          rf_we;
  logic [31:0]   fetch_dat, data_dat;
  logic          mem_we;
  logic [31:0]   alu_res, load_val;
  logic          alu_valid_op;
  logic          unused_addr_hi;

  assign opcode = ir[31:28];

  // Port A carries the ALU destination or the store source; port B the ALU source or the address register.
  assign rf_ra_a = (opcode == 4'h2) ? ir[27:24] : ir[15:12];
  assign rf_ra_b = (opcode == 4'h8) ? ir[7:4]   : ir[23:20];

  assign unused_addr_hi = ^rf_rd_b[31:AW];

  rapids_mem #(.MEM_WORDS(MEM_WORDS)) mmu (
    .clk        (clk),
    .fetch_addr (pc),
    .fetch_dat  (fetch_dat),
    .data_addr  (rf_rd_b[AW-1:0]),
    .data_dat   (data_dat),
    .wr_en      (mem_we & ~reset_n),
    .wr_mask    (ir[19:16]),
    .wr_dat     (rf_rd_a)
  );

  rapids_regfile #(.NUM_REGS(NUM_REGS)) D (
    .clk       (clk),
    .rst       (reset_n),
    .rd_addr_a (rf_ra_a),
    .rd_dat_a  (rf_rd_a),
    .rd_addr_b (rf_ra_b),
    .rd_dat_b  (rf_rd_b),
    .wr_en     (rf_we),
    .wr_addr   (rf_wa),
    .wr_dat    (rf_wd)
  );

  always_comb begin
    alu_res      = rf_rd_a;
    alu_valid_op = 1'b1;
    case (ir[27:24])
      4'h0:    alu_res = rf_rd_a + rf_rd_b;
      4'h1:    alu_res = rf_rd_a - rf_rd_b;
      4'h2:    alu_res = rf_rd_a & rf_rd_b;
      4'h3:    alu_res = rf_rd_a | rf_rd_b;
      4'h4:    alu_res = rf_rd_a ^ rf_rd_b;
      default: alu_valid_op = 1'b0;
    endcase
  end

  always_comb begin
    load_val = '0;
    for (int i = 0; i < 4; i++) begin
      if (ir[16+i]) load_val[8*i +: 8] = data_dat[8*i +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    rf_we     = 1'b0;
    rf_wa     = ir[15:12];
    rf_wd     = alu_res;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (ctl.go && !ctl.halt) begin
          pc_nxt    = '0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (ctl.halt) begin
          state_nxt = IDLE;
        end else begin
          ir_nxt    = fetch_dat;
          pc_nxt    = pc + AW'(1);
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = FETCH;
        case (opcode)
          4'h9: begin
            if (ir[27:20] == 8'hEF) begin
              rf_we = 1'b1;
              rf_wa = ir[19:16];
              rf_wd = {16'h0000, ir[15:0]};
            end
          end
          4'h8: rf_we = alu_valid_op;
          4'h2: mem_we = 1'b1;
          4'h1: state_nxt = MEM;
          4'hF: state_nxt = IDLE;
          default: ;
        endcase
        // A halt lets this cycle's write land but abandons a pending load.
        if (ctl.halt) state_nxt = IDLE;
      end
      MEM: begin
        rf_we     = 1'b1;
        rf_wa     = ir[27:24];
        rf_wd     = load_val;
        state_nxt = ctl.halt ? IDLE : FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end
endmodule

// File: tb/tb_rapids_cpu.sv
// Bench for rapids_cpu: an instruction-level interpreter predicts registers and memory at every return to IDLE.
module tb_rapids_cpu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  rapids_cpu_if ctl_if();

  rapids_cpu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctl     (ctl_if)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  logic [31:0] m_reg [16];
  logic [31:0] m_mem [256];
  logic [16*32-1:0]  exp_regs_q [$];
  logic [256*32-1:0] exp_mem_q  [$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] v);
    dut.mmu.memory[a] = v;
    m_mem[a] = v;
  endtask

  // Interpreter: edge 0 samples go; the k-th instruction is fetched on edge t+1 and executed on t+2.
  // A cut edge models halt (writes on that edge land) or reset (nothing on that edge lands).
  function automatic void model_run(input int cut, input bit is_reset);
    int t = 0;
    int pc = 0;
    for (int n = 0; n < 64; n++) begin
      logic [31:0] ir, a, b, v;
      int e;
      if (cut > 0 && t + 1 >= cut) break;
      ir = m_mem[pc];
      pc = (pc + 1) % 256;
      e = t + 2;
      if (cut > 0 && (is_reset ? e >= cut : e > cut)) break;
      case (ir[31:28])
        4'h9: if (ir[27:20] == 8'hEF) m_reg[ir[19:16]] = {16'h0, ir[15:0]};
        4'h8: begin
          a = m_reg[ir[15:12]];
          b = m_reg[ir[7:4]];
          case (ir[27:24])
            4'h0: m_reg[ir[15:12]] = a + b;
            4'h1: m_reg[ir[15:12]] = a - b;
            4'h2: m_reg[ir[15:12]] = a & b;
            4'h3: m_reg[ir[15:12]] = a | b;
            4'h4: m_reg[ir[15:12]] = a ^ b;
            default: ;
          endcase
        end
        4'h2: begin
          a = m_reg[ir[23:20]];
          b = m_reg[ir[27:24]];
          for (int i = 0; i < 4; i++)
            if (ir[16+i]) m_mem[a[7:0]][8*i +: 8] = b[8*i +: 8];
        end
        default: ;
      endcase
      if (ir[31:28] == 4'hF) break;
      if (ir[31:28] == 4'h1) begin
        if (cut > 0 && e == cut) break;
        e = e + 1;
        if (cut > 0 && (is_reset ? e >= cut : e > cut)) break;
        a = m_reg[ir[23:20]];
        v = 32'h0;
        for (int i = 0; i < 4; i++)
          if (ir[16+i]) v[8*i +: 8] = m_mem[a[7:0]][8*i +: 8];
        m_reg[ir[27:24]] = v;
      end
      t = e;
    end
    if (is_reset)
      for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
  endfunction

  function automatic void push_expected();
    logic [16*32-1:0]  r;
    logic [256*32-1:0] m;
    for (int i = 0; i < 16; i++)  r[32*i +: 32] = m_reg[i];
    for (int i = 0; i < 256; i++) m[32*i +: 32] = m_mem[i];
    exp_regs_q.push_back(r);
    exp_mem_q.push_back(m);
  endfunction

  // Monitor: every return to IDLE is compared against the oldest prediction.
  initial begin
    logic [1:0] prev_st, cur_st;
    logic [16*32-1:0]  r;
    logic [256*32-1:0] m;
    int bad_idx;
    prev_st = 2'd0;
    forever begin
      @(negedge clk);
      cur_st = dut.state;
      if (mon_en && prev_st != 2'd0 && cur_st == 2'd0) begin
        if (exp_regs_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_idle: got idle with no run outstanding, required none");
        end else begin
          r = exp_regs_q.pop_front();
          m = exp_mem_q.pop_front();
          for (int i = 0; i < 16; i++)
            check32($sformatf("reg%0d", i), dut.D.registers[i], r[32*i +: 32]);
          bad_idx = -1;
          for (int i = 0; i < 256; i++)
            if (bad_idx < 0 && dut.mmu.memory[i] !== m[32*i +: 32]) bad_idx = i;
          n_vec++;
          if (bad_idx >= 0) begin
            n_bad++;
            $display("FAIL memory[%0d]: got %08h expected %08h", bad_idx,
                     dut.mmu.memory[bad_idx], m[32*bad_idx +: 32]);
          end
        end
      end
      prev_st = cur_st;
    end
  end

  task automatic wait_drain();
    int c = 0;
    while (exp_regs_q.size() != 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (exp_regs_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d runs outstanding, required 0", exp_regs_q.size());
      exp_regs_q.delete();
      exp_mem_q.delete();
    end
    @(negedge clk);
  endtask

  // Pulses go, then over edges 1..40 optionally raises halt, reset or a stray go on a single edge.
  task automatic run(input int halt_e, input int reset_e, input int go_e);
    model_run(halt_e > 0 ? halt_e : reset_e, reset_e > 0);
    push_expected();
    @(negedge clk);
    ctl_if.go = 1'b1;
    @(negedge clk);
    ctl_if.go = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      ctl_if.halt = (k == halt_e);
      reset_n     = (k == reset_e);
      ctl_if.go   = (k == go_e);
      @(negedge clk);
    end
    ctl_if.halt = 1'b0;
    reset_n     = 1'b0;
    ctl_if.go   = 1'b0;
    wait_drain();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel, k;
    w   = $urandom;
    sel = $urandom_range(0, 4);
    case (sel)
      0: begin
        w[31:28] = 4'h9;
        if ($urandom_range(0, 7) != 0) w[27:20] = 8'hEF;
        w[19:16] = 4'($urandom_range(0, 13));
      end
      1: begin
        w[31:28] = 4'h8;
        w[27:24] = 4'($urandom_range(0, 7));
        w[15:12] = 4'($urandom_range(0, 13));
      end
      2: begin
        w[31:28] = 4'h2;
        w[23:20] = {3'b111, 1'($urandom)};
      end
      3: begin
        w[31:28] = 4'h1;
        w[27:24] = 4'($urandom_range(0, 13));
        w[23:20] = {3'b111, 1'($urandom)};
      end
      default: begin
        k = $urandom_range(0, 10);
        w[31:28] = (k == 0) ? 4'h0 : (k <= 5) ? 4'(k + 2) : 4'(k + 4);
      end
    endcase
    return w;
  endfunction

  // r14/r15 hold data addresses in 0x40..0xFF, clear of the program at 0..12.
  task automatic load_random_prog();
    logic [7:0] lo;
    lo = 8'($urandom_range(64, 255));
    poke(0, {4'h9, 8'hEF, 4'hE, 8'($urandom), lo});
    lo = 8'($urandom_range(64, 255));
    poke(1, {4'h9, 8'hEF, 4'hF, 8'($urandom), lo});
    for (int i = 2; i < 12; i++) poke(i, rand_instr());
    poke(12, 32'hF000_0000);
    for (int a = 64; a < 256; a++) poke(a, $urandom);
  endtask

  initial begin
    logic [1:0] st;
    int mode;
    reset_n     = 1'b1;
    ctl_if.go   = 1'b0;
    ctl_if.halt = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;

    st = dut.state;
    check32("reset_state", 32'(st), 32'd0);
    check32("reset_pc", 32'(dut.pc), 32'd0);
    check32("reset_ir", dut.ir, 32'd0);
    for (int i = 0; i < 16; i++) begin
      m_reg[i] = 32'h0;
      check32($sformatf("reset_reg%0d", i), dut.D.registers[i], 32'h0);
    end
    for (int a = 0; a < 256; a++) poke(a, 32'h0);
    mon_en = 1'b1;

    // Arithmetic, then store/load through r3.
    poke(0, 32'h9EF1_0004); poke(1, 32'h9EF2_0006); poke(2, 32'h8080_1020);
    poke(3, 32'h9EF3_0040); poke(4, 32'h213F_0000); poke(5, 32'h143F_0000);
    poke(6, 32'hF000_0000);
    run(0, 0, 0);
    check32("arith_r1", dut.D.registers[1], 32'd10);
    check32("arith_r2", dut.D.registers[2], 32'd6);
    check32("ldst_r3", dut.D.registers[3], 32'd64);
    check32("ldst_r4", dut.D.registers[4], 32'd10);
    check32("ldst_mem64", dut.mmu.memory[64], 32'd10);

    // Byte masks.
    poke(64, 32'h0); poke(65, 32'hAABB_CCDD);
    poke(0, 32'h9EF3_0041); poke(1, 32'h113F_0000); poke(2, 32'h9EF3_0040);
    poke(3, 32'h2133_0000); poke(4, 32'h9EF3_0041); poke(5, 32'h1534_0000);
    poke(6, 32'hF000_0000);
    run(0, 0, 0);
    check32("mask_r1", dut.D.registers[1], 32'hAABB_CCDD);
    check32("mask_store", dut.mmu.memory[64], 32'h0000_CCDD);
    check32("mask_load", dut.D.registers[5], 32'h00BB_0000);

    // Subtract wraps below zero; a following run's add wraps back.
    poke(0, 32'h9EF1_0000); poke(1, 32'h9EF2_0001); poke(2, 32'h8100_1020);
    poke(3, 32'hF000_0000);
    run(0, 0, 0);
    check32("sub_wrap", dut.D.registers[1], 32'hFFFF_FFFF);
    poke(0, 32'h8000_1020); poke(1, 32'hF000_0000);
    run(0, 0, 0);
    check32("add_wrap", dut.D.registers[1], 32'h0);

    // Halt instruction stops after instruction 0.
    poke(0, 32'h9EF1_0007); poke(1, 32'hF000_0000); poke(2, 32'h9EF2_0009);
    run(0, 0, 0);
    check32("halt_instr_r1", dut.D.registers[1], 32'd7);
    check32("halt_instr_r2", dut.D.registers[2], 32'd1);

    // Halt pin on the edge that executes instruction 1.
    poke(0, 32'h9EF6_0011); poke(1, 32'h9EF7_0022); poke(2, 32'h9EF8_0033);
    poke(3, 32'h9EF9_0044); poke(4, 32'hF000_0000);
    run(4, 0, 0);
    check32("halt_pin_pc", 32'(dut.pc), 32'd2);
    check32("halt_pin_r7", dut.D.registers[7], 32'h22);
    repeat (10) @(negedge clk);
    check32("halt_pin_r8_later", dut.D.registers[8], m_reg[8]);
    check32("halt_pin_r9_later", dut.D.registers[9], m_reg[9]);

    // Reset mid-program, then a fresh run from PC 0.
    load_random_prog();
    run(0, 7, 0);
    run(0, 0, 0);

    for (int it = 0; it < 40; it++) begin
      load_random_prog();
      mode = $urandom_range(0, 3);
      case (mode)
        1:       run($urandom_range(1, 30), 0, 0);
        2:       run(0, $urandom_range(2, 20), 0);
        3:       run(0, 0, $urandom_range(3, 10));
        default: run(0, 0, 0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by time limit, required completion");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end
endmodule
